reg_bank_ctrl: RTL and testbench
================================

Name: reg_bank_ctrl

Overview:
Parametrised successor to the controller's flat register bank. Adds per-register access modes (read/write, read-only hardware status, write-1-to-clear event), byte-lane write strobes, and a registered request/acknowledge host port. Exposes every register as a flattened bus to the SPI datapath. Raises an interrupt when any event bit is pending.

Parameters:
ADDR_W, 4, register address width; N = 2**ADDR_W registers
DATA_W, 32, register width; must be a multiple of 8
RO_MASK, {N{1'b0}}, bit i = 1 makes register i read-only, reflecting hw_in slice i
W1C_MASK, {N{1'b0}}, bit i = 1 makes register i write-1-to-clear, set by hw_set slice i
- RO_MASK & W1C_MASK must be 0; otherwise an elaboration-time error.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low
req  in  1  host request strobe, one transfer per cycle
wr  in  1  1 = write, 0 = read; qualified by req
address  in  ADDR_W  register index
data_in  in  DATA_W  write data
wstrb  in  DATA_W/8  byte-lane write enables
data_out  out  DATA_W  registered read data
ack  out  1  one-cycle acknowledge
err  out  1  valid with ack; write attempted to a read-only register
irq  out  1  OR of all bits of all W1C registers
hw_in  in  N*DATA_W  status values for RO registers, slice i at [(i+1)*DATA_W-1 -: DATA_W]
hw_set  in  N*DATA_W  event set pulses for W1C registers, same slicing
chip_out  out  N*DATA_W  current value of every register, same slicing

Behaviour:
- Reset (rst = 0, asynchronous): all storage 0; data_out, ack, err, irq are 0. Deassertion is taken synchronously by the next clk edge.
- Reset mid-transfer: a pending ack is dropped. No write completes.
- Accept: req = 1 at edge k gives ack = 1 for exactly the cycle after edge k. Back-to-back req is legal every cycle, and ack then stays high.
- RW write: for each lane b with wstrb[b] = 1, reg[address][8b+7:8b] <= data_in lane. Other lanes hold.
- RO write: storage unchanged; err = 1 alongside ack.
- W1C write: bit j clears where data_in[j] = 1 and its lane strobe is set.
- W1C hardware set: each cycle, reg[i] |= hw_set slice i.
- Set and clear of the same bit in the same cycle: set wins, and the bit stays 1.
- Read: data_out <= value at edge k, i.e. before any same-edge update. RO registers return hw_in sampled at edge k. Reads never clear W1C bits. err = 0.
- Writes leave data_out holding the last read value.
- wstrb is ignored on reads; wstrb = 0 on a write still acks with no update.
- chip_out: RW and W1C slices show the stored value. RO slices show hw_in combinationally; RO registers have no storage.
- irq: combinational OR over the W1C flops. It rises the cycle after an hw_set pulse and falls the cycle after the clearing write.
- Every address is legal (N = 2**ADDR_W), so there is no decode error.

Decomposition:
- Shared package reg_bank_pkg:
  - access-mode constants MODE_RW, MODE_RO, MODE_W1C
  - function mode_of(i) derived from the masks
  - function lane_mask(wstrb) expanding strobes to a DATA_W bit mask
- One sub-module, reg_bank_cell: a single register holding mode, lane-merge, and the W1C set/clear priority logic. It is instantiated N times in a generate loop. The top level keeps the host handshake, read mux, err/ack, and irq reduction.

Test Plan:
- Reset/default: hold rst = 0 for 3 cycles, then release. Required: data_out, ack, err, irq = 0, and chip_out = 0 with hw_in = 0.
- RW byte strobes (ADDR_W = 4, DATA_W = 32): write 0xAABBCCDD, wstrb = 4'hF, to reg 2. Then write 0x11223344 with wstrb = 4'b0101. Read reg 2 -> 0xAA22CC44, ack one cycle after req, err = 0.
- RO (RO_MASK bit 5): hw_in slice 5 = 0x0000BEEF, write 0xFFFFFFFF to reg 5. Required: err = 1 with ack. Read -> 0x0000BEEF. Change hw_in to 0x1234 -> chip_out slice 5 = 0x1234 the same cycle.
- W1C and irq (W1C_MASK bit 7): pulse hw_set slice 7 = 0x5 -> irq = 1 next cycle, read -> 0x5. Write 0x1 -> reg 7 = 0x4, irq still 1. Write 0x4 -> reg 7 = 0, irq = 0.
- W1C collision: same cycle, hw_set bit 0 = 1 and write 0x1 to reg 7 -> bit 0 stays 1.
- Back-to-back and mid-op reset: req high 4 cycles (write r1, read r1, write r3, read r3) -> ack high 4 cycles, and the read of r1 returns the pre-write value only if issued in the same cycle as its write. Assert rst during the third req -> ack falls immediately, and r3 = 0.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register bank: access modes, per-register mode
// lookup from the RO/W1C masks, and byte-strobe to bit-mask expansion.
package reg_bank_pkg;

    localparam int MAX_REGS   = 256;
    localparam int MAX_DATA_W = 256;
    localparam int MAX_STRB   = MAX_DATA_W / 8;

    typedef enum logic [1:0] {
        MODE_RW  = 2'd0,
        MODE_RO  = 2'd1,
        MODE_W1C = 2'd2
    } mode_e;

    // RO takes precedence only for robustness; overlapping masks are rejected at elaboration.
    function automatic mode_e mode_of(
        input int                    idx,
        input logic [MAX_REGS-1:0]   ro_mask,
        input logic [MAX_REGS-1:0]   w1c_mask
    );
        if (ro_mask[idx[7:0]]) begin
            return MODE_RO;
        end
        if (w1c_mask[idx[7:0]]) begin
            return MODE_W1C;
        end
        return MODE_RW;
    endfunction

    function automatic logic [MAX_DATA_W-1:0] lane_mask(input logic [MAX_STRB-1:0] wstrb);
        logic [MAX_DATA_W-1:0] m;
        m = '0;
        for (int b = 0; b < MAX_STRB; b++) begin
            m[8*b +: 8] = {8{wstrb[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/reg_bank_cell.sv
// One register of the bank. The access mode selects plain storage with byte-lane
// merge, write-1-to-clear event storage, or a storage-free pass-through of hw_in.
module reg_bank_cell
    import reg_bank_pkg::*;
#(
    parameter int    DATA_W = 32,
    parameter mode_e MODE   = MODE_RW
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0] i_wmask,
    input  logic [DATA_W-1:0] i_hw_in,
    input  logic [DATA_W-1:0] i_hw_set,
    output logic [DATA_W-1:0] o_value
);

    generate
        if (MODE == MODE_RO) begin : g_ro
            logic w_unused;
            assign w_unused = ^{i_clk, i_rst_n, i_we, i_wdata, i_wmask, i_hw_set};
            assign o_value  = i_hw_in;
        end else if (MODE == MODE_W1C) begin : g_w1c
            logic [DATA_W-1:0] r_value;
            logic [DATA_W-1:0] w_clear;
            logic              w_unused;

            assign w_unused = ^i_hw_in;
            assign w_clear  = i_we ? (i_wdata & i_wmask) : '0;

            // Clear is applied first so a same-cycle hardware set always survives.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_value <= '0;
                end else begin
                    r_value <= (r_value & ~w_clear) | i_hw_set;
                end
            end

            assign o_value = r_value;
        end else begin : g_rw
            logic [DATA_W-1:0] r_value;
            logic [DATA_W-1:0] w_update;
            logic              w_unused;

            assign w_unused = ^{i_hw_in, i_hw_set};
            assign w_update = i_we ? i_wmask : '0;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_value <= '0;
                end else begin
                    r_value <= (r_value & ~w_update) | (i_wdata & w_update);
                end
            end

            assign o_value = r_value;
        end
    endgenerate

endmodule

// File: rtl/reg_bank_ctrl.sv
// Parametrised register bank with per-register access modes, byte strobes,
// a registered req/ack host port, a flattened register view and an event irq.
module reg_bank_ctrl
    import reg_bank_pkg::*;
#(
    parameter int                       ADDR_W   = 4,
    parameter int                       DATA_W   = 32,
    parameter logic [(2**ADDR_W)-1:0]   RO_MASK  = '0,
    parameter logic [(2**ADDR_W)-1:0]   W1C_MASK = '0
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_req,
    input  logic                           i_wr,
    input  logic [ADDR_W-1:0]              i_address,
    input  logic [DATA_W-1:0]              i_data_in,
    input  logic [DATA_W/8-1:0]            i_wstrb,
    output logic [DATA_W-1:0]              o_data_out,
    output logic                           o_ack,
    output logic                           o_err,
    output logic                           o_irq,
    input  logic [(2**ADDR_W)*DATA_W-1:0]  i_hw_in,
    input  logic [(2**ADDR_W)*DATA_W-1:0]  i_hw_set,
    output logic [(2**ADDR_W)*DATA_W-1:0]  o_chip_out
);

    localparam int N = 2 ** ADDR_W;
    localparam logic [MAX_REGS-1:0] RO_EXT  = MAX_REGS'(RO_MASK);
    localparam logic [MAX_REGS-1:0] W1C_EXT = MAX_REGS'(W1C_MASK);

    generate
        if ((RO_MASK & W1C_MASK) != '0) begin : g_bad_masks
            $error("reg_bank_ctrl: RO_MASK and W1C_MASK overlap");
        end
        if ((DATA_W % 8) != 0 || DATA_W > MAX_DATA_W || DATA_W < 8) begin : g_bad_width
            $error("reg_bank_ctrl: DATA_W must be a multiple of 8 in [8, 256]");
        end
        if (ADDR_W < 1 || ADDR_W > 8) begin : g_bad_addr
            $error("reg_bank_ctrl: ADDR_W must be in [1, 8]");
        end
    endgenerate

    logic [DATA_W-1:0] w_regs [N];
    logic [DATA_W-1:0] w_lane;
    logic [N-1:0]      w_irq_src;
    logic              w_wr_xfer;

    logic [DATA_W-1:0] r_data_out;
    logic              r_ack;
    logic              r_err;

    assign w_lane    = DATA_W'(lane_mask(MAX_STRB'(i_wstrb)));
    assign w_wr_xfer = i_req & i_wr;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cell
            localparam mode_e CELL_MODE = mode_of(gi, RO_EXT, W1C_EXT);

            reg_bank_cell #(
                .DATA_W (DATA_W),
                .MODE   (CELL_MODE)
            ) u_cell (
                .i_clk    (i_clk),
                .i_rst_n  (i_rst_n),
                .i_we     (w_wr_xfer && (i_address == ADDR_W'(gi))),
                .i_wdata  (i_data_in),
                .i_wmask  (w_lane),
                .i_hw_in  (i_hw_in[gi*DATA_W +: DATA_W]),
                .i_hw_set (i_hw_set[gi*DATA_W +: DATA_W]),
                .o_value  (w_regs[gi])
            );

            assign o_chip_out[gi*DATA_W +: DATA_W] = w_regs[gi];

            if (CELL_MODE == MODE_W1C) begin : g_irq
                assign w_irq_src[gi] = |w_regs[gi];
            end else begin : g_no_irq
                assign w_irq_src[gi] = 1'b0;
            end
        end
    endgenerate

    // Reads sample the register view before this edge's update; writes keep the last read data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_ack <= i_req;
            r_err <= w_wr_xfer & RO_MASK[i_address];
            if (i_req && !i_wr) begin
                r_data_out <= w_regs[i_address];
            end
        end
    end

    assign o_data_out = r_data_out;
    assign o_ack      = r_ack;
    assign o_err      = r_err;
    assign o_irq      = |w_irq_src;

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Scoreboard bench for reg_bank_ctrl: directed scenarios plus random traffic
// checked against a behavioural model of the register bank.
module tb_reg_bank_ctrl;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int N      = 16;
    localparam logic [N-1:0] RO_M  = 16'h0220;
    localparam logic [N-1:0] W1C_M = 16'h1080;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req = 1'b0;
    logic              wr = 1'b0;
    logic [3:0]        addr = '0;
    logic [31:0]       wdata = '0;
    logic [3:0]        strb = '0;
    logic [N*32-1:0]   hw_in = '0;
    logic [N*32-1:0]   hw_set = '0;
    logic [31:0]       data_out;
    logic              ack;
    logic              err;
    logic              irq;
    logic [N*32-1:0]   chip_out;

    reg_bank_ctrl #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RO_MASK  (RO_M),
        .W1C_MASK (W1C_M)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_req      (req),
        .i_wr       (wr),
        .i_address  (addr),
        .i_data_in  (wdata),
        .i_wstrb    (strb),
        .o_data_out (data_out),
        .o_ack      (ack),
        .o_err      (err),
        .o_irq      (irq),
        .i_hw_in    (hw_in),
        .i_hw_set   (hw_set),
        .o_chip_out (chip_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t            exp_q[$];
    logic [31:0]     m_reg [N];
    logic [31:0]     m_last_read = '0;
    logic [N*32-1:0] pend_hw_in = '0;
    int              n_vec = 0;
    int              n_err = 0;
    bit              chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [31:0] m_view(input int i);
        return RO_M[i] ? hw_in[i*32 +: 32] : m_reg[i];
    endfunction

    function automatic logic m_irq();
        logic any;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (W1C_M[i] && m_reg[i] != 32'h0) any = 1'b1;
        end
        return any;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < N; i++) m_reg[i] = '0;
        m_last_read = '0;
    endtask

    // Drive one clock's worth of inputs and advance the model to the state after that edge.
    task automatic drive_cycle(input bit r, input bit w, input logic [3:0] a,
                               input logic [31:0] d, input logic [3:0] s,
                               input logic [N*32-1:0] set);
        exp_t e;
        @(negedge clk);
        req = r; wr = w; addr = a; wdata = d; strb = s;
        hw_set = set; hw_in = pend_hw_in;
        if (r) begin
            if (!w) m_last_read = m_view(a);
            e.err  = w & RO_M[a];
            e.data = m_last_read;
            exp_q.push_back(e);
            if (w && !RO_M[a]) begin
                for (int b = 0; b < 4; b++) begin
                    if (s[b]) begin
                        if (W1C_M[a]) m_reg[a][8*b +: 8] = m_reg[a][8*b +: 8] & ~d[8*b +: 8];
                        else          m_reg[a][8*b +: 8] = d[8*b +: 8];
                    end
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (W1C_M[i]) m_reg[i] = m_reg[i] | set[i*32 +: 32];
        end
    endtask

    task automatic idle();
        drive_cycle(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, '0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: ack every cycle, scoreboard pop on ack, full register view and irq.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (chk_en) begin
                check("ack", 32'(ack), 32'(req));
                if (ack) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL scoreboard: ack with no pending transfer at %0t", $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("rd_data", data_out, e.data);
                        check("err", 32'(err), 32'(e.err));
                    end
                end
                for (int i = 0; i < N; i++) begin
                    check($sformatf("chip_out[%0d]", i), chip_out[i*32 +: 32], m_view(i));
                end
                check("irq", 32'(irq), 32'(m_irq()));
            end
        end
    end

    initial begin
        logic [N*32-1:0] sv;
        logic [31:0]     d1;
        logic [31:0]     d3;
        model_reset();

        // Reset / defaults
        repeat (3) @(negedge clk);
        check("rst_data_out", data_out, 32'h0);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        for (int i = 0; i < N; i++) check("rst_chip_out", chip_out[i*32 +: 32], 32'h0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        idle();

        // RW byte strobes
        drive_cycle(1, 1, 4'd2, 32'hAABBCCDD, 4'hF, '0);
        drive_cycle(1, 1, 4'd2, 32'h11223344, 4'b0101, '0);
        drive_cycle(1, 0, 4'd2, 32'h0, 4'h0, '0);
        settle();
        check("rw_strobe_read", data_out, 32'hAA22CC44);
        check("rw_strobe_err", 32'(err), 32'h0);
        drive_cycle(1, 1, 4'd2, 32'hFFFFFFFF, 4'h0, '0);
        settle();
        check("rw_zero_strb", chip_out[2*32 +: 32], 32'hAA22CC44);
        idle();

        // RO register
        pend_hw_in[5*32 +: 32] = 32'h0000BEEF;
        drive_cycle(1, 1, 4'd5, 32'hFFFFFFFF, 4'hF, '0);
        settle();
        check("ro_err", 32'(err), 32'h1);
        check("ro_ack", 32'(ack), 32'h1);
        drive_cycle(1, 0, 4'd5, 32'h0, 4'h0, '0);
        settle();
        check("ro_read", data_out, 32'h0000BEEF);
        pend_hw_in[5*32 +: 32] = 32'h00001234;
        idle();
        #1;
        check("ro_passthru", chip_out[5*32 +: 32], 32'h00001234);

        // W1C and irq
        sv = '0;
        sv[7*32 +: 32] = 32'h5;
        drive_cycle(0, 0, 4'd0, 32'h0, 4'h0, sv);
        settle();
        check("w1c_irq_set", 32'(irq), 32'h1);
        drive_cycle(1, 0, 4'd7, 32'h0, 4'h0, '0);
        settle();
        check("w1c_read", data_out, 32'h5);
        drive_cycle(1, 1, 4'd7, 32'h1, 4'hF, '0);
        settle();
        check("w1c_clr1", chip_out[7*32 +: 32], 32'h4);
        check("w1c_irq_hold", 32'(irq), 32'h1);
        drive_cycle(1, 1, 4'd7, 32'h4, 4'hF, '0);
        settle();
        check("w1c_clr2", chip_out[7*32 +: 32], 32'h0);
        check("w1c_irq_clr", 32'(irq), 32'h0);

        // W1C set/clear collision
        sv = '0;
        sv[7*32 +: 32] = 32'h1;
        drive_cycle(1, 1, 4'd7, 32'h1, 4'hF, sv);
        settle();
        check("w1c_collision", chip_out[7*32 +: 32], 32'h1);
        drive_cycle(1, 1, 4'd7, 32'h1, 4'hF, '0);
        idle();

        // Back-to-back transfers
        d1 = $urandom;
        d3 = $urandom;
        drive_cycle(1, 1, 4'd1, d1, 4'hF, '0);
        drive_cycle(1, 0, 4'd1, 32'h0, 4'h0, '0);
        settle();
        check("b2b_read_r1", data_out, d1);
        drive_cycle(1, 1, 4'd3, d3, 4'hF, '0);
        drive_cycle(1, 0, 4'd3, 32'h0, 4'h0, '0);
        settle();
        check("b2b_read_r3", data_out, d3);
        idle();

        // Reset during the third back-to-back transfer
        drive_cycle(1, 1, 4'd1, $urandom, 4'hF, '0);
        drive_cycle(1, 0, 4'd1, 32'h0, 4'h0, '0);
        drive_cycle(1, 1, 4'd3, 32'hCAFEF00D, 4'hF, '0);
        #2;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        req    = 1'b0;
        hw_set = '0;
        #1;
        check("midrst_ack_drop", 32'(ack), 32'h0);
        check("midrst_r3", chip_out[3*32 +: 32], 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        drive_cycle(1, 0, 4'd3, 32'h0, 4'h0, '0);
        settle();
        check("post_rst_r3", data_out, 32'h0);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++) begin
                sv[i*32 +: 32] = ($urandom_range(0, 7) == 0) ? ($urandom & $urandom & $urandom) : 32'h0;
                if ($urandom_range(0, 15) == 0) pend_hw_in[i*32 +: 32] = $urandom;
            end
            drive_cycle(($urandom_range(0, 3) != 0), $urandom_range(0, 1) != 0,
                        4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)), sv);
        end
        idle();
        idle();
        settle();

        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
